// File: rtl/seg_scan_decoder.sv
// Samples muxed active-low 7-seg pins, captures each digit after STABLE_CYCLES+1 equal samples, assembles a frame.
// Frame appears one edge after the last slot write; a frame completing while out_valid is held is dropped and flags overrun.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_SETTLE, S_CAPTURE, S_HOLD} state_t;

    logic [SW-1:0]           samp_q, samp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] slot_val_q, slot_val_d;
    logic [NUM_DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic                    done_q, done_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;

    logic                    same, one_low, capture, accept, load;
    logic [NUM_DIGITS-1:0]   an_low;
    logic [3:0]              dec_val;
    logic                    dec_blank, dec_err;

    // Returns {blank, err, value}.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode = {2'b00, 4'h0};
            7'b1111001: decode = {2'b00, 4'h1};
            7'b0100100: decode = {2'b00, 4'h2};
            7'b0110000: decode = {2'b00, 4'h3};
            7'b0011001: decode = {2'b00, 4'h4};
            7'b0010010: decode = {2'b00, 4'h5};
            7'b1111111: decode = {2'b10, 4'hF};
            default:    decode = {2'b01, 4'hE};
        endcase
    endfunction

    always_comb begin
        samp_d  = {seg_in, an_in};
        same    = (samp_d == samp_q);
        an_low  = ~samp_q[NUM_DIGITS-1:0];
        one_low = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
        capture = same && (state_q == S_CAPTURE) && one_low;
        {dec_blank, dec_err, dec_val} = decode(samp_q[SW-1 -: 7]);

        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (cnt_d == CNT_MAX) begin
            state_d = S_HOLD;
        end else if (cnt_d == CNT_ARM) begin
            state_d = S_CAPTURE;
        end else begin
            state_d = S_SETTLE;
        end

        seen_d       = seen_q;
        slot_val_d   = slot_val_q;
        slot_blank_d = slot_blank_q;
        slot_err_d   = slot_err_q;
        done_d       = 1'b0;
        if (capture) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (an_low[k]) begin
                    slot_val_d[4*k +: 4] = dec_val;
                    slot_blank_d[k]      = dec_blank;
                    slot_err_d[k]        = dec_err;
                    seen_d[k]            = 1'b1;
                end
            end
            if (seen_d == '1) begin
                seen_d = '0;
                done_d = 1'b1;
            end
        end

        // A completed frame is presented on the edge after the last slot write.
        accept  = valid_q && out_ready;
        load    = done_q && (!valid_q || out_ready);
        dig_d   = dig_q;
        blank_d = blank_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            dig_d   = slot_val_q;
            blank_d = slot_blank_q;
            err_d   = slot_err_q;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            ovr_d = 1'b0;
        end else if (done_q && !load) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q       <= '1;
            cnt_q        <= '0;
            state_q      <= S_SETTLE;
            seen_q       <= '0;
            slot_val_q   <= '1;
            slot_blank_q <= '1;
            slot_err_q   <= '0;
            done_q       <= 1'b0;
            dig_q        <= '1;
            blank_q      <= '1;
            err_q        <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            samp_q       <= samp_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            seen_q       <= seen_d;
            slot_val_q   <= slot_val_d;
            slot_blank_q <= slot_blank_d;
            slot_err_q   <= slot_err_d;
            done_q       <= done_d;
            dig_q        <= dig_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
        end
    end

    assign digits_out = dig_q;
    assign blank_out  = blank_q;
    assign err_out    = err_q;
    assign out_valid  = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed vector table plus randomized scan, both checked every cycle against a run-length reference model.
module tb_seg_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] ZZ = 7'b0000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [6:0]     seg_in;
    logic [N-1:0]   an_in;
    logic [4*N-1:0] digits_out;
    logic [N-1:0]   blank_out;
    logic [N-1:0]   err_out;
    logic           out_valid;
    logic           out_ready;
    logic           overrun;

    seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .digits_out (digits_out),
        .blank_out  (blank_out),
        .err_out    (err_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] glyph [6] = '{G0, G1, G2, G3, G4, G5};

    // Reference model: run length of the current sampled value, capture when it reaches S+1.
    logic [10:0] m_samp;
    int          m_run;
    logic [3:0]  m_seen;
    logic [3:0]  m_sval [4];
    logic        m_sblank [4];
    logic        m_serr [4];
    logic        m_pend;
    logic [15:0] m_dig;
    logic [3:0]  m_blank, m_err;
    logic        m_valid, m_ovr;

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got ovr=%b vld=%b err=%b blk=%b dig=%h, expected ovr=%b vld=%b err=%b blk=%b dig=%h",
                     name, act[25], act[24], act[23:20], act[19:16], act[15:0],
                     exp[25], exp[24], exp[23:20], exp[19:16], exp[15:0]);
        end
    endtask

    function automatic logic [25:0] dut_vec();
        return {overrun, out_valid, err_out, blank_out, digits_out};
    endfunction

    task automatic model_edge();
        logic [10:0] nw;
        int          lows, k;
        logic [3:0]  v;
        logic        b, e, pend_now;
        if (!rst_n) begin
            m_samp = '1; m_run = 1; m_seen = '0; m_pend = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_sval[i] = 4'hF; m_sblank[i] = 1'b1; m_serr[i] = 1'b0;
            end
            m_dig = 16'hFFFF; m_blank = 4'hF; m_err = 4'h0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            pend_now = 1'b0;
            if (m_pend) begin
                if (!m_valid || out_ready) begin
                    for (int i = 0; i < 4; i++) begin
                        m_dig[4*i +: 4] = m_sval[i]; m_blank[i] = m_sblank[i]; m_err[i] = m_serr[i];
                    end
                    if (m_valid) m_ovr = 1'b0;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0; m_ovr = 1'b0;
            end
            nw = {seg_in, an_in};
            if (nw == m_samp) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else m_run = 1;
            m_samp = nw;
            if (m_run == S + 1) begin
                lows = 0; k = 0;
                for (int i = 0; i < 4; i++) if (!an_in[i]) begin lows++; k = i; end
                if (lows == 1) begin
                    v = 4'hE; b = 1'b0; e = 1'b1;
                    if (seg_in == 7'h7F) begin v = 4'hF; b = 1'b1; e = 1'b0; end
                    else for (int g = 0; g < 6; g++) if (seg_in == glyph[g]) begin v = 4'(g); e = 1'b0; end
                    m_sval[k] = v; m_sblank[k] = b; m_serr[k] = e; m_seen[k] = 1'b1;
                    if (m_seen == 4'hF) begin m_seen = '0; pend_now = 1'b1; end
                end
            end
            m_pend = pend_now;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model", dut_vec(), {m_ovr, m_valid, m_err, m_blank, m_dig});
    endtask

    typedef struct {
        logic        rst;
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        rdy;
        int          cyc;
        logic        v;
        logic [15:0] dig;
        logic [3:0]  blk;
        logic [3:0]  err;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Scan 3,1,4,5: frame appears 6 edges into the last digit.
        vecs.push_back('{1'b1, G3, 4'b1110, 1'b1, 10, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b1101, 1'b1, 10, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b1011, 1'b1, 10, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G5, 4'b0111, 1'b1, 5,  1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G5, 4'b0111, 1'b1, 1,  1'b1, 16'h5413, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G5, 4'b0111, 1'b1, 1,  1'b0, 16'h5413, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G5, 4'b0111, 1'b1, 3,  1'b0, 16'h5413, 4'h0, 4'h0, 1'b0});
        // Blank on digit 2, undecodable on digit 0.
        vecs.push_back('{1'b1, ZZ, 4'b1110, 1'b1, 10, 1'b0, 16'h5413, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b1101, 1'b1, 10, 1'b0, 16'h5413, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, BL, 4'b1011, 1'b1, 10, 1'b0, 16'h5413, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b0111, 1'b1, 5,  1'b0, 16'h5413, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b0111, 1'b1, 1,  1'b1, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b0111, 1'b1, 4,  1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        // Gap, 4-edge glitch on digit 0, multi-anode pattern: none of them captured.
        vecs.push_back('{1'b1, BL, 4'b1111, 1'b1, 4,  1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G5, 4'b1110, 1'b1, 10, 1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G2, 4'b1110, 1'b1, 4,  1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, BL, 4'b1111, 1'b1, 2,  1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G3, 4'b1101, 1'b1, 10, 1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b1100, 1'b1, 10, 1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G0, 4'b1011, 1'b1, 10, 1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b0111, 1'b1, 5,  1'b0, 16'h4F1E, 4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b0111, 1'b1, 1,  1'b1, 16'h1035, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b0111, 1'b1, 1,  1'b0, 16'h1035, 4'h0, 4'h0, 1'b0});
        // Two frames with out_ready low: first held, second dropped, then one handshake.
        vecs.push_back('{1'b1, G0, 4'b1110, 1'b0, 10, 1'b0, 16'h1035, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b1101, 1'b0, 10, 1'b0, 16'h1035, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G2, 4'b1011, 1'b0, 10, 1'b0, 16'h1035, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G3, 4'b0111, 1'b0, 6,  1'b1, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G3, 4'b0111, 1'b0, 4,  1'b1, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b1110, 1'b0, 10, 1'b1, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G5, 4'b1101, 1'b0, 10, 1'b1, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b1011, 1'b0, 10, 1'b1, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G2, 4'b0111, 1'b0, 6,  1'b1, 16'h3210, 4'h0, 4'h0, 1'b1});
        vecs.push_back('{1'b1, G2, 4'b0111, 1'b1, 1,  1'b0, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G2, 4'b0111, 1'b1, 3,  1'b0, 16'h3210, 4'h0, 4'h0, 1'b0});
        // Reset after two digits; only post-reset captures form the next frame.
        vecs.push_back('{1'b1, G5, 4'b1110, 1'b1, 10, 1'b0, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G4, 4'b1101, 1'b1, 10, 1'b0, 16'h3210, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, G4, 4'b1101, 1'b1, 1,  1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G0, 4'b1011, 1'b1, 10, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G1, 4'b0111, 1'b1, 10, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G2, 4'b1110, 1'b1, 10, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G3, 4'b1101, 1'b1, 5,  1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G3, 4'b1101, 1'b1, 1,  1'b1, 16'h1032, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, G3, 4'b1101, 1'b1, 1,  1'b0, 16'h1032, 4'h0, 4'h0, 1'b0});

        rst_n = 1'b0; out_ready = 1'b1; seg_in = '0; an_in = '0;
        for (int i = 0; i < 3; i++) begin
            seg_in = 7'($urandom_range(127));
            an_in  = 4'($urandom_range(15));
            tick();
            check("reset_hold", dut_vec(), {1'b0, 1'b0, 4'h0, 4'hF, 16'hFFFF});
        end
        rst_n = 1'b1; seg_in = BL; an_in = 4'hF;
        repeat (2) tick();
        check("after_release", dut_vec(), {1'b0, 1'b0, 4'h0, 4'hF, 16'hFFFF});

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst; seg_in = vecs[i].seg; an_in = vecs[i].an; out_ready = vecs[i].rdy;
            repeat (vecs[i].cyc) tick();
            check($sformatf("row%0d", i), dut_vec(),
                  {vecs[i].ovr, vecs[i].v, vecs[i].err, vecs[i].blk, vecs[i].dig});
        end

        rst_n = 1'b1;
        for (int it = 0; it < 400; it++) begin
            int r, hold;
            rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            r = $urandom_range(9);
            if (r < 7)       an_in = ~(4'b0001 << $urandom_range(3));
            else if (r == 7) an_in = 4'hF;
            else             an_in = 4'($urandom_range(15));
            r = $urandom_range(9);
            if (r < 7)       seg_in = glyph[$urandom_range(5)];
            else if (r == 7) seg_in = BL;
            else             seg_in = 7'($urandom_range(127));
            hold = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                out_ready = ($urandom_range(3) != 0);
                tick();
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
